if_fetch_unit: RTL and testbench

//  Instruction-fetch stage of the MIPS pipeline: owns the PC and issues instruction-memory requests.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_pc_sel.sv | 36 +++
 rtl/if_fetch_unit.sv | 137 +++++++++++++
 tb/tb_if_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the MIPS instruction-fetch stage.
// The IF_DELAY_SLOT_EN build option is consumed by if_fetch_unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection: forms branch/jump targets from IF/ID and picks the next fetch address.
// Purely combinational; the fetch FSM decides when next_pc is actually taken.
module fetch_pc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic        sample_en,
  input  logic [31:0] if_pc4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        redirect_pend,
  input  logic [31:0] pend_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_target,
  output logic [31:0] next_pc
);

  logic [31:0] target_raw;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    redirect_valid  = sample_en && (branch_taken || jump);
    target_raw      = branch_taken ? (if_pc4 + branch_offset)
                                   : jump_target(if_pc4, jump_index);
    redirect_target = {target_raw[31:2], 2'b00};
    next_pc         = pc4;
    if (redirect_valid) begin
      next_pc = redirect_target;
    end else if (redirect_pend) begin
      next_pc = pend_target;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: owns the PC, issues imem requests and drives the IF/ID register.
// Build option IF_DELAY_SLOT_EN: defined keeps the delay-slot word, undefined flushes it.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc4, next_pc;
  logic [31:0]  skid_instr, pend_target, redirect_target, load_instr;
  logic         discard, redirect_pend, redirect_valid;
  logic         advance, capture, load, set_pend, drop;

  assign pc4       = pc + PC_INC;
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  fetch_pc_sel u_pc_sel (
    .pc4             (pc4),
    .sample_en       (if_valid && !stall_i),
    .if_pc4          (if_pc4),
    .branch_taken    (branch_taken),
    .branch_offset   (branch_offset),
    .jump            (jump),
    .jump_index      (jump_index),
    .redirect_pend   (redirect_pend),
    .pend_target     (pend_target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .next_pc         (next_pc)
  );

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    capture    = 1'b0;
    load       = 1'b0;
    set_pend   = 1'b0;
    drop       = 1'b0;
    load_instr = imem_rdata;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (discard) begin
            drop    = 1'b1;
            advance = 1'b1;
          end else if (stall_i) begin
            capture    = 1'b1;
            state_next = HOLD;
          end else begin
            advance = 1'b1;
            load    = 1'b1;
          end
        end else if (redirect_valid) begin
          set_pend = 1'b1;
        end
      end
      HOLD: begin
        if (!stall_i) begin
          advance    = 1'b1;
          load       = 1'b1;
          load_instr = skid_instr;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
`ifndef IF_DELAY_SLOT_EN
    // Flush build: the word arriving alongside a redirect is the wrong-path one.
    if (redirect_valid) load = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      if_valid      <= 1'b0;
      if_instr      <= NOP_INSTR;
      if_pc4        <= 32'h0;
      skid_instr    <= NOP_INSTR;
      discard       <= 1'b0;
      redirect_pend <= 1'b0;
      pend_target   <= 32'h0;
    end else begin
      state <= state_next;

      if (advance) begin
        pc            <= next_pc;
        redirect_pend <= 1'b0;
      end else if (set_pend) begin
        redirect_pend <= 1'b1;
        pend_target   <= redirect_target;
      end

      if (drop) begin
        discard <= 1'b0;
      end else if (set_pend) begin
`ifdef IF_DELAY_SLOT_EN
        discard <= 1'b0;
`else
        discard <= 1'b1;
`endif
      end

      if (capture) skid_instr <= imem_rdata;

      // A live IF/ID entry is consumed by any unstalled cycle; only a load refills it.
      if (load) begin
        if_valid <= 1'b1;
        if_instr <= load_instr;
        if_pc4   <= pc4;
      end else if (!stall_i) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: zero-wait, slow ack, stall, branch, jump, mid-wait reset.
// Expectations follow the build selected by IF_DELAY_SLOT_EN.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_taken, jump;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr, if_pc4;

  int n_tests = 0;
  int n_fail  = 0;
  int wait_cycles = 0;
  int wait_cnt    = 0;
  logic stray_ack = 1'b0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4)
  );

  // Instruction memory model: rdata = addr, ack after wait_cycles idle cycles.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt >= wait_cycles) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr;
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_0000;
        wait_cnt   = wait_cnt + 1;
      end
    end else begin
      imem_ack   = stray_ack;
      imem_rdata = 32'hDEAD_BEEF;
      wait_cnt   = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (!(branch_taken && jump)) else $error("illegal branch_taken and jump together");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc4(input logic [31:0] v);
    for (int i = 0; i < 20; i++) begin
      if (if_valid && if_pc4 == v) return;
      tick();
    end
    check("wait_pc4 timeout", if_pc4, v);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_offset = 32'h0; jump_index = 26'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    check("rst req", imem_req, 0);
    check("rst addr", imem_addr, 32'h0);
    check("rst valid", if_valid, 0);
    check("rst instr", if_instr, 32'h0);
    check("rst pc4", if_pc4, 32'h0);

    // Zero-wait streaming
    rst = 1'b0;
    tick();
    check("first req", imem_req, 1);
    check("first addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zw valid", if_valid, 1);
      check("zw instr", if_instr, 32'(4 * i));
      check("zw pc4", if_pc4, 32'(4 * i + 4));
      check("zw addr", imem_addr, 32'(4 * i + 4));
    end

    // Stall arriving with the ack at 0x10
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall req", imem_req, 0);
      check("stall valid", if_valid, 1);
      check("stall instr", if_instr, 32'h0C);
      check("stall pc4", if_pc4, 32'h10);
    end
    stall_i = 1'b0;
    tick();
    check("unstall instr", if_instr, 32'h10);
    check("unstall pc4", if_pc4, 32'h14);
    check("unstall addr", imem_addr, 32'h14);
    check("unstall req", imem_req, 1);

    // Slow ack: three idle cycles before the ack for 0x14
    wait_cycles = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("slow addr", imem_addr, 32'h14);
      check("slow req", imem_req, 1);
      check("slow valid", if_valid, 0);
    end
    tick();
    check("slow ack valid", if_valid, 1);
    check("slow ack instr", if_instr, 32'h14);
    check("slow next addr", imem_addr, 32'h18);
    tick();
    check("slow pulse end", if_valid, 0);

    // Backward branch from if_pc4=0x24 to 0x14
    wait_cycles = 0;
    wait_pc4(32'h24);
    check("br pre addr", imem_addr, 32'h24);
    branch_taken = 1'b1; branch_offset = 32'hFFFF_FFF0;
    tick();
    branch_taken = 1'b0;
    check("br target addr", imem_addr, 32'h14);
`ifdef IF_DELAY_SLOT_EN
    check("br slot valid", if_valid, 1);
    check("br slot instr", if_instr, 32'h24);
`else
    check("br squash", if_valid, 0);
`endif
    tick();
    check("br tgt valid", if_valid, 1);
    check("br tgt instr", if_instr, 32'h14);
    check("br tgt pc4", if_pc4, 32'h18);

    // Branch up to 0x4000_0004 to set up the jump
    branch_taken = 1'b1; branch_offset = 32'h3FFF_FFEC;
    tick();
    branch_taken = 1'b0;
    check("br2 addr", imem_addr, 32'h4000_0004);
    tick();
    check("j pre pc4", if_pc4, 32'h4000_0008);
    check("j pre addr", imem_addr, 32'h4000_0008);

    // Jump while the 0x4000_0008 request waits on a slow ack
    wait_cycles = 3;
    jump = 1'b1; jump_index = 26'h000_0040;
    tick();
    jump = 1'b0;
    check("j hold addr", imem_addr, 32'h4000_0008);
    check("j valid", if_valid, 0);
    tick();
    check("j hold addr2", imem_addr, 32'h4000_0008);
    tick();
    check("j hold addr3", imem_addr, 32'h4000_0008);
    tick();
    check("j target addr", imem_addr, 32'h4000_0100);
`ifdef IF_DELAY_SLOT_EN
    check("j slot valid", if_valid, 1);
    check("j slot instr", if_instr, 32'h4000_0008);
`else
    check("j late dropped", if_valid, 0);
`endif
    wait_cycles = 0;
    tick();
    check("j tgt valid", if_valid, 1);
    check("j tgt instr", if_instr, 32'h4000_0100);
    check("j tgt pc4", if_pc4, 32'h4000_0104);

    // Wrapping branch to 0x80, then reset during the slow wait there
    branch_taken = 1'b1; branch_offset = 32'hBFFF_FF7C;
    tick();
    branch_taken = 1'b0;
    check("wrap addr", imem_addr, 32'h80);
    wait_cycles = 3;
    tick();
    check("wait 0x80 addr", imem_addr, 32'h80);
    check("wait 0x80 req", imem_req, 1);
    rst = 1'b1;
    tick();
    check("mid rst req", imem_req, 0);
    check("mid rst addr", imem_addr, 32'h0);
    check("mid rst valid", if_valid, 0);
    check("mid rst instr", if_instr, 32'h0);
    check("mid rst pc4", if_pc4, 32'h0);
    rst = 1'b0; stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0; wait_cycles = 0;
    check("stray ignored", if_valid, 0);
    check("post rst req", imem_req, 1);
    check("post rst addr", imem_addr, 32'h0);
    tick();
    check("post rst valid", if_valid, 1);
    check("post rst instr", if_instr, 32'h0);
    check("post rst pc4", if_pc4, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
